instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscvx_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 16 +
 rtl/instr_fetch_skid.sv | 41 ++++
 rtl/instr_fetch.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/riscvx_pkg.sv
// riscvx_pkg
//   Shared constants and types for the fetch stage.
//   NOP_INSTR_DEF : bubble word (addi x0,x0,0) presented to decode
//   RESET_PC_DEF  : default first fetch address after reset
//   fetch_state_e : fetch FSM state encoding
package riscvx_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_BUF  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits are never used.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Instruction memory request/response bus.
//   imem_req   : fetch request; imem_addr stable while high until imem_ready
//   imem_addr  : word-aligned fetch address
//   imem_ready : memory completes the outstanding request this cycle
//   imem_rdata : instruction word, valid only with imem_ready
//   master = fetch stage, slave = instruction memory
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_skid.sv
// fetch_skid
//   One-entry buffer holding an instruction word and its PC while decode
//   is stalled.
//   clk, rst          : clock, synchronous active-high reset
//   i_load            : capture i_instr/i_pc, mark full
//   i_clear           : empty the buffer (drain or flush); wins over i_load
//   o_instr, o_pc     : buffered contents
//   o_full            : buffer holds a valid entry
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_full
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_full;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_full  <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_full  = r_full;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction fetch stage: drives the instruction memory bus and the
//   IF/ID pipeline register, with a one-entry skid for decode stalls and
//   flush/redirect handling that respects the memory handshake.
//   clk, rst          : clock, synchronous active-high reset
//   imem              : instruction memory bus (master side)
//   stall_ID          : decode cannot accept; IF/ID holds
//   redirect          : taken branch/jump; flush and refetch at redirect_pc
//   redirect_pc       : new PC (low two bits ignored)
//   Instr_ID, PC_ID   : IF/ID instruction and its address
//   valid_ID          : 1 = real instruction, 0 = bubble (Instr_ID = NOP_INSTR)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_RUN  | requesting pc_r; accepted word goes to IF/ID or skid
//   ST_BUF  | skid full, decode stalled, no request issued
//   ST_DROP | stale request still outstanding; its data is discarded
module instr_fetch
  import riscvx_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  input  logic                 stall_ID,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          Instr_ID,
  output logic [31:0]          PC_ID,
  output logic                 valid_ID
);

  fetch_state_e r_state, w_state_nxt;

  logic [31:0] r_pc, r_tgt, r_instr_id, r_pc_id;
  logic        r_valid_id;

  logic        w_ifid_mem, w_ifid_skid, w_ifid_bubble;
  logic        w_pc_inc, w_pc_redir, w_pc_tgt, w_tgt_load;
  logic        w_skid_load, w_skid_clear, w_skid_full;
  logic [31:0] w_skid_instr, w_skid_pc, w_redir_pc;

  assign w_redir_pc = word_align(redirect_pc);

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (imem.imem_rdata),
    .i_pc    (r_pc),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc),
    .o_full  (w_skid_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (redirect)
          w_state_nxt = imem.imem_ready ? ST_RUN : ST_DROP;
        else if (stall_ID && imem.imem_ready)
          w_state_nxt = ST_BUF;
      end
      ST_BUF:  if (redirect || !stall_ID) w_state_nxt = ST_RUN;
      ST_DROP: if (imem.imem_ready)       w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Output / control strobes
  always_comb begin
    imem.imem_req = 1'b0;
    w_ifid_mem    = 1'b0;
    w_ifid_skid   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_pc_inc      = 1'b0;
    w_pc_redir    = 1'b0;
    w_pc_tgt      = 1'b0;
    w_tgt_load    = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_clear  = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        imem.imem_req = !rst;
        if (redirect) begin
          w_ifid_bubble = 1'b1;
          // Without ready the request must complete before moving the address.
          if (imem.imem_ready) w_pc_redir = 1'b1;
          else                 w_tgt_load = 1'b1;
        end else if (stall_ID) begin
          if (imem.imem_ready) begin
            w_skid_load = 1'b1;
            w_pc_inc    = 1'b1;
          end
        end else if (imem.imem_ready) begin
          w_ifid_mem = 1'b1;
          w_pc_inc   = 1'b1;
        end else begin
          w_ifid_bubble = 1'b1;
        end
      end
      ST_BUF: begin
        if (redirect) begin
          w_ifid_bubble = 1'b1;
          w_pc_redir    = 1'b1;
          w_skid_clear  = 1'b1;
        end else if (!stall_ID && w_skid_full) begin
          w_ifid_skid  = 1'b1;
          w_skid_clear = 1'b1;
        end
      end
      ST_DROP: begin
        imem.imem_req = !rst;
        w_ifid_bubble = 1'b1;
        w_tgt_load    = redirect;
        if (imem.imem_ready) begin
          // A redirect arriving with the stale completion is the newest target.
          if (redirect) w_pc_redir = 1'b1;
          else          w_pc_tgt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem.imem_addr = word_align(r_pc);

  // PC, redirect target and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_tgt      <= '0;
      r_instr_id <= NOP_INSTR;
      r_pc_id    <= '0;
      r_valid_id <= 1'b0;
    end else begin
      if (w_pc_redir)    r_pc <= w_redir_pc;
      else if (w_pc_tgt) r_pc <= r_tgt;
      else if (w_pc_inc) r_pc <= r_pc + 32'd4;

      if (w_tgt_load) r_tgt <= w_redir_pc;

      if (w_ifid_bubble) begin
        r_instr_id <= NOP_INSTR;
        r_valid_id <= 1'b0;
      end else if (w_ifid_mem) begin
        r_instr_id <= imem.imem_rdata;
        r_pc_id    <= r_pc;
        r_valid_id <= 1'b1;
      end else if (w_ifid_skid) begin
        r_instr_id <= w_skid_instr;
        r_pc_id    <= w_skid_pc;
        r_valid_id <= 1'b1;
      end
    end
  end

  assign Instr_ID = r_instr_id;
  assign PC_ID    = r_pc_id;
  assign valid_ID = r_valid_id;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Directed bench for instr_fetch. A behavioural memory returns a word
//   derived from the address; expected PCs are queued whenever the stream
//   is started or redirected, and popped each time a new instruction lands
//   in IF/ID.
module tb_instr_fetch;
  import riscvx_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_ID = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_rdy = 1'b0;
  logic [31:0] Instr_ID, PC_ID;
  logic        valid_ID;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_instr, m_pc;
  logic        m_valid;

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .stall_ID    (stall_ID),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .Instr_ID    (Instr_ID),
    .PC_ID       (PC_ID),
    .valid_ID    (valid_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0001;
  endfunction

  always_comb begin
    imem_bus.imem_ready = mem_rdy & imem_bus.imem_req;
    imem_bus.imem_rdata = imem_bus.imem_ready ? mem_word(imem_bus.imem_addr) : 32'hxxxx_xxxx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Advance one clock and check IF/ID against the model for the inputs
  // that were applied at that edge.
  task automatic tick();
    logic p_rst, p_redir, p_stall, p_req, p_rdy;
    logic [31:0] p_addr, e;
    @(negedge clk);
    p_rst   = rst;
    p_redir = redirect;
    p_stall = stall_ID;
    p_req   = imem_bus.imem_req;
    p_rdy   = imem_bus.imem_ready;
    p_addr  = imem_bus.imem_addr;
    @(posedge clk);
    #1;
    chk("addr_align", {30'd0, imem_bus.imem_addr[1:0]}, 32'd0);
    if (p_req && !p_rdy && !p_rst) begin
      chk("req_held", 32'(imem_bus.imem_req), 32'd1);
      chk("addr_held", imem_bus.imem_addr, p_addr);
    end
    if (p_rst) begin
      m_instr = NOP; m_pc = 32'd0; m_valid = 1'b0;
      chk("rst_instr", Instr_ID, m_instr);
      chk("rst_pc", PC_ID, m_pc);
      chk("rst_valid", 32'(valid_ID), 32'd0);
    end else if (p_redir) begin
      m_instr = NOP; m_valid = 1'b0;
      chk("flush_valid", 32'(valid_ID), 32'd0);
      chk("flush_instr", Instr_ID, m_instr);
    end else if (p_stall) begin
      chk("hold_valid", 32'(valid_ID), 32'(m_valid));
      chk("hold_instr", Instr_ID, m_instr);
      if (m_valid) chk("hold_pc", PC_ID, m_pc);
    end else if (valid_ID) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      m_pc = e; m_instr = mem_word(e); m_valid = 1'b1;
      chk("sb_pc", PC_ID, m_pc);
      chk("sb_instr", Instr_ID, m_instr);
    end else begin
      m_instr = NOP; m_valid = 1'b0;
      chk("bubble_instr", Instr_ID, m_instr);
    end
  endtask

  initial begin
    m_instr = NOP; m_pc = '0; m_valid = 1'b0;

    // Reset
    rst = 1'b1; mem_rdy = 1'b1;
    tick();
    tick();
    chk("req_in_rst", 32'(imem_bus.imem_req), 32'd0);
    rst = 1'b0;
    fill(RST_PC);
    #1;
    chk("first_req", 32'(imem_bus.imem_req), 32'd1);
    chk("first_addr", imem_bus.imem_addr, RST_PC);

    // Zero-wait stream, then three wait states on 0x8
    tick();
    tick();
    chk("addr_8", imem_bus.imem_addr, 32'h8);
    mem_rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("wait_valid", 32'(valid_ID), 32'd0);
    end
    chk("wait_addr", imem_bus.imem_addr, 32'h8);
    mem_rdy = 1'b1;
    repeat (4) tick();

    // Decode stall for two cycles while memory is ready
    stall_ID = 1'b1;
    tick();
    chk("buf_req0", 32'(imem_bus.imem_req), 32'd0);
    tick();
    chk("buf_req1", 32'(imem_bus.imem_req), 32'd0);
    stall_ID = 1'b0;
    repeat (3) tick();

    // Redirect to 0x10, then redirect while 0x10 is waiting
    redirect = 1'b1; redirect_pc = 32'h10; fill(32'h10);
    tick();
    redirect = 1'b0; mem_rdy = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h101; fill(32'h100);
    tick();
    chk("drop_addr", imem_bus.imem_addr, 32'h10);
    chk("drop_req", 32'(imem_bus.imem_req), 32'd1);
    redirect = 1'b0;
    tick();
    mem_rdy = 1'b1;
    tick();
    chk("after_drop_addr", imem_bus.imem_addr, 32'h100);
    chk("after_drop_valid", 32'(valid_ID), 32'd0);
    repeat (2) tick();

    // Second redirect during DROP replaces the target
    mem_rdy = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; fill(32'h200);
    tick();
    redirect_pc = 32'h300; fill(32'h300);
    tick();
    redirect = 1'b0; mem_rdy = 1'b1;
    tick();
    chk("tgt_overwrite_addr", imem_bus.imem_addr, 32'h300);
    repeat (2) tick();

    // Redirect while stalled in BUF
    stall_ID = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40; fill(32'h40);
    tick();
    chk("buf_redir_addr", imem_bus.imem_addr, 32'h40);
    chk("buf_redir_req", 32'(imem_bus.imem_req), 32'd1);
    redirect = 1'b0; stall_ID = 1'b0;
    repeat (2) tick();

    // Stall with no data returning
    stall_ID = 1'b1; mem_rdy = 1'b0;
    tick();
    stall_ID = 1'b0; mem_rdy = 1'b1;
    tick();

    // Address wrap at the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; fill(32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);
    repeat (2) tick();

    // Reset in the middle of an outstanding request
    mem_rdy = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_req", 32'(imem_bus.imem_req), 32'd0);
    rst = 1'b0; mem_rdy = 1'b1; fill(RST_PC);
    #1;
    chk("restart_addr", imem_bus.imem_addr, RST_PC);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
